// File: rtl/fft_pingpong_buffer.sv
// Double-buffered (ping-pong) sample memory for the FFT datapath.
// The writer fills one bank while the reader drains the other; ownership of a
// bank passes on wr_done / rd_done. Reads may use bit-reversed addressing so a
// radix-2 stage can consume samples in butterfly order straight from the bank.
module fft_pingpong_buffer #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 12,
  parameter int ADDR_LAG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_done,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_bitrev,
  input  logic              rd_done,
  output logic              rd_avail,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;

  logic              wr_bank;
  logic              rd_bank;
  logic [1:0]        full;
  logic [1:0]        full_next;
  logic [ADDR_W-1:0] wr_addr_lag;
  logic [ADDR_W-1:0] rd_addr_eff;
  logic              wr_fire;
  logic              wr_swap;
  logic              rd_fire;
  logic              rd_swap;

  // Bank 0 occupies the lower half, bank 1 the upper half; the bank bit is the MSB.
  logic [DATA_W-1:0] mem [0:2*DEPTH-1];

  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) r[i] = a[ADDR_W-1-i];
    return r;
  endfunction

  // wr_addr runs ADDR_LAG cycles ahead of its data; realign it here.
  generate
    if (ADDR_LAG == 0) begin : g_nolag
      assign wr_addr_lag = wr_addr;
    end else begin : g_lag
      logic [ADDR_W-1:0] addr_dly_p [0:ADDR_LAG-1];
      // Address delay line aligning wr_addr with wr_en/wr_data.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < ADDR_LAG; i++) addr_dly_p[i] <= '0;
        end else begin
          addr_dly_p[0] <= wr_addr;
          for (int i = 1; i < ADDR_LAG; i++) addr_dly_p[i] <= addr_dly_p[i-1];
        end
      end
      assign wr_addr_lag = addr_dly_p[ADDR_LAG-1];
    end
  endgenerate

  assign wr_ready    = !full[wr_bank];
  assign rd_avail    = full[rd_bank];
  assign wr_fire     = wr_en & wr_ready;
  assign wr_swap     = wr_done & wr_ready;
  assign rd_fire     = rd_en & rd_avail;
  assign rd_swap     = rd_done & rd_avail;
  assign rd_addr_eff = rd_bitrev ? bitrev(rd_addr) : rd_addr;

  // Full-flag update; writer and reader always own different banks, so both
  // swaps can land in the same cycle without touching the same bit.
  always_comb begin
    full_next = full;
    if (wr_swap) full_next[wr_bank] = 1'b1;
    if (rd_swap) full_next[rd_bank] = 1'b0;
  end

  // Bank ownership, full flags and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full      <= 2'b00;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      full <= full_next;
      if (wr_swap) wr_bank <= ~wr_bank;
      if (rd_swap) rd_bank <= ~rd_bank;
      if ((wr_en | wr_done) & !wr_ready) overflow  <= 1'b1;
      if ((rd_en | rd_done) & !rd_avail) underflow <= 1'b1;
    end
  end

  // Sample memory write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[{wr_bank, wr_addr_lag}] <= wr_data;
  end

  // Registered read port, one-cycle latency; rd_data holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire) rd_data <= mem[{rd_bank, rd_addr_eff}];
    end
  end

endmodule

// File: tb/tb_fft_pingpong_buffer.sv
// Directed bench for fft_pingpong_buffer (16-word banks, one-cycle address lag).
// Read results are checked through a queue of expected words filled when reads are issued.
module tb_fft_pingpong_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic [3:0]  wr_addr = '0;
  logic        wr_done = 1'b0;
  logic        wr_ready;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic        rd_bitrev = 1'b0;
  logic        rd_done = 1'b0;
  logic        rd_avail;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        overflow;
  logic        underflow;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q [$];
  logic [15:0] mdl [2][16];
  logic        m_wb = 1'b0;
  logic        m_rb = 1'b0;

  fft_pingpong_buffer #(.DATA_W(16), .ADDR_W(4), .ADDR_LAG(1)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_data(wr_data), .wr_addr(wr_addr), .wr_done(wr_done), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_bitrev(rd_bitrev), .rd_done(rd_done), .rd_avail(rd_avail),
    .rd_data(rd_data), .rd_valid(rd_valid), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and check the read port against the scoreboard.
  task automatic tick();
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      chk("rd_valid", 32'(rd_valid), 1);
      chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
    end else begin
      chk("rd_valid_idle", 32'(rd_valid), 0);
    end
  endtask

  task automatic rd(input logic [3:0] a, input logic br);
    logic [3:0] e;
    e = br ? {a[0], a[1], a[2], a[3]} : a;
    rd_en = 1'b1; rd_addr = a; rd_bitrev = br;
    exp_q.push_back(mdl[m_rb][e]);
    tick();
    rd_en = 1'b0; rd_bitrev = 1'b0;
  endtask

  // Fill the current write bank with base+addr; wr_done rides with the last word.
  // With rdone set, rd_done and a read of address 7 share that final cycle.
  task automatic fill(input int base, input bit rdone);
    for (int i = 0; i <= 16; i++) begin
      wr_addr = 4'(i);
      wr_en   = (i > 0);
      wr_data = 16'(base + i - 1);
      if (i > 0) mdl[m_wb][i-1] = 16'(base + i - 1);
      if (i == 16) begin
        wr_done = 1'b1;
        if (rdone) begin
          rd_done = 1'b1; rd_en = 1'b1; rd_addr = 4'd7;
          exp_q.push_back(mdl[m_rb][7]);
        end
      end
      tick();
    end
    wr_en = 1'b0; wr_done = 1'b0; rd_done = 1'b0; rd_en = 1'b0; wr_addr = '0;
    m_wb = ~m_wb;
    if (rdone) m_rb = ~m_rb;
  endtask

  initial begin
    // Power-on reset values
    @(posedge clk); #1;
    chk("rst_wr_ready", 32'(wr_ready), 1);
    chk("rst_rd_avail", 32'(rd_avail), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_underflow", 32'(underflow), 0);
    rst = 1'b0;
    tick();

    // Read with nothing available
    rd_en = 1'b1; rd_addr = 4'd2;
    tick();
    rd_en = 1'b0;
    chk("uf_early", 32'(underflow), 1);
    chk("uf_early_rd_data", 32'(rd_data), 0);

    // Fill bank0 with addr+0x100, hand over, read address 5
    fill(32'h100, 1'b0);
    chk("fill0_rd_avail", 32'(rd_avail), 1);
    chk("fill0_wr_ready", 32'(wr_ready), 1);
    rd(4'd5, 1'b0);

    // Asynchronous reset in the middle of traffic
    rd_en = 1'b1; rd_addr = 4'd6;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_wr_ready", 32'(wr_ready), 1);
    chk("mid_rst_rd_avail", 32'(rd_avail), 0);
    chk("mid_rst_rd_valid", 32'(rd_valid), 0);
    chk("mid_rst_overflow", 32'(overflow), 0);
    chk("mid_rst_underflow", 32'(underflow), 0);
    tick();
    rd_en = 1'b0; rst = 1'b0; m_wb = 1'b0; m_rb = 1'b0;
    tick();

    // Refill bank0, bit-reversed reads
    fill(32'h400, 1'b0);
    chk("refill_rd_avail", 32'(rd_avail), 1);
    rd(4'b0001, 1'b1);
    rd(4'b0011, 1'b1);
    rd(4'b0010, 1'b0);

    // Fill bank1 too: both full, writer back-pressured
    fill(32'h200, 1'b0);
    chk("both_full_wr_ready", 32'(wr_ready), 0);
    chk("both_full_rd_avail", 32'(rd_avail), 1);
    chk("both_full_no_ovf", 32'(overflow), 0);
    wr_addr = 4'd3;
    tick();
    wr_en = 1'b1; wr_data = 16'hdead;
    tick();
    wr_en = 1'b0;
    chk("drop_overflow", 32'(overflow), 1);
    rd(4'd3, 1'b0);

    // Release bank0 to the writer
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0; m_rb = ~m_rb;
    chk("release_wr_ready", 32'(wr_ready), 1);
    chk("release_rd_avail", 32'(rd_avail), 1);
    rd(4'd9, 1'b0);

    // Refill bank0 with simultaneous wr_done / rd_done
    fill(32'h300, 1'b1);
    chk("swap_wr_ready", 32'(wr_ready), 1);
    chk("swap_rd_avail", 32'(rd_avail), 1);
    chk("swap_overflow", 32'(overflow), 1);
    chk("swap_underflow", 32'(underflow), 0);
    rd(4'd15, 1'b0);
    rd(4'd3, 1'b0);

    // Drain: no bank readable, then a read attempt
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0; m_rb = ~m_rb;
    chk("drain_rd_avail", 32'(rd_avail), 0);
    chk("drain_wr_ready", 32'(wr_ready), 1);
    chk("drain_underflow", 32'(underflow), 0);
    rd_en = 1'b1; rd_addr = 4'd1;
    tick();
    rd_en = 1'b0;
    chk("uf_underflow", 32'(underflow), 1);
    chk("uf_rd_data_hold", 32'(rd_data), 32'h0303);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
